// File: rtl/irda_pkg.sv
// Shared IrDA MIR definitions: CRC-CCITT16 constants and the RX CRC checker state type.
package irda_pkg;

  localparam logic [15:0] CRC16_POLY    = 16'h1021;
  localparam logic [15:0] CRC16_PRESET  = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUE = 16'h1D0F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } rx_crc_state_t;

endpackage

// File: rtl/irda_crc16_step.sv
// One-bit combinational CRC-CCITT16 update (MSB first), shared by the MIR TX and RX paths.
module irda_crc16_step
  import irda_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic        din,
  output logic [15:0] crc_out
);

  logic feedback;

  assign feedback = crc_in[15] ^ din;
  assign crc_out  = {crc_in[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);

endmodule

// File: rtl/irda_mir_rx_crc_check.sv
// MIR receive CRC checker: forwards payload bits with the trailing FCS stripped
// and reports CRC / short-frame status at the closing flag.
module irda_mir_rx_crc_check
  import irda_pkg::*;
#(
  parameter int MIN_DATA_BITS = 8,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic             rx_start,
  input  logic             mir_rxbit_enable,
  input  logic             rxdin,
  input  logic             rx_end,
  output logic             rxdout,
  output logic             rxdout_valid,
  output logic             crc_done,
  output logic             crc_ok,
  output logic             crc_err,
  output logic             short_frame,
  output logic [CNT_W-1:0] bit_count
);

  localparam logic [CNT_W-1:0] FILL_BITS   = CNT_W'(16);
  localparam logic [CNT_W-1:0] SHORT_LIMIT = CNT_W'(16 + MIN_DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  rx_crc_state_t    state;
  logic [15:0]      crc;
  logic [15:0]      delay_line;

  logic [15:0]      crc_src;
  logic [15:0]      crc_step;
  logic [15:0]      crc_next;
  logic [CNT_W-1:0] cnt_src;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_next;
  logic [15:0]      delay_src;
  logic [15:0]      delay_shift;
  logic             short_next;
  logic             ok_next;

  // rx_start restarts from the preset so a bit arriving with it is bit 1 of the new frame.
  assign crc_src     = rx_start ? CRC16_PRESET : crc;
  assign cnt_src     = rx_start ? '0 : bit_count;
  assign delay_src   = rx_start ? 16'h0000 : delay_line;
  assign cnt_inc     = (cnt_src == CNT_MAX) ? cnt_src : cnt_src + 1'b1;
  assign delay_shift = {delay_src[14:0], rxdin};

  irda_crc16_step u_crc_step (
    .crc_in  (crc_src),
    .din     (rxdin),
    .crc_out (crc_step)
  );

  // End-of-frame verdict uses the values including a bit accepted alongside rx_end.
  assign crc_next   = mir_rxbit_enable ? crc_step : crc;
  assign cnt_next   = mir_rxbit_enable ? cnt_inc : bit_count;
  assign short_next = (cnt_next != CNT_MAX) && (cnt_next < SHORT_LIMIT);
  assign ok_next    = !short_next && (crc_next == CRC16_RESIDUE);

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state        <= IDLE;
      crc          <= CRC16_PRESET;
      delay_line   <= 16'h0000;
      bit_count    <= '0;
      rxdout       <= 1'b0;
      rxdout_valid <= 1'b0;
      crc_done     <= 1'b0;
      crc_ok       <= 1'b0;
      crc_err      <= 1'b0;
      short_frame  <= 1'b0;
    end else begin
      rxdout       <= 1'b0;
      rxdout_valid <= 1'b0;
      crc_done     <= 1'b0;

      if (rx_start) begin
        state       <= FILL;
        crc_ok      <= 1'b0;
        crc_err     <= 1'b0;
        short_frame <= 1'b0;
        if (mir_rxbit_enable) begin
          crc        <= crc_step;
          bit_count  <= cnt_inc;
          delay_line <= delay_shift;
        end else begin
          crc        <= CRC16_PRESET;
          bit_count  <= '0;
          delay_line <= 16'h0000;
        end
      end else begin
        case (state)
          FILL, RUN: begin
            if (mir_rxbit_enable) begin
              crc        <= crc_step;
              bit_count  <= cnt_inc;
              delay_line <= delay_shift;
              if (state == RUN) begin
                rxdout_valid <= 1'b1;
                rxdout       <= delay_line[15];
              end else if (cnt_inc == FILL_BITS) begin
                state <= RUN;
              end
            end
            if (rx_end) begin
              state       <= DONE;
              crc_done    <= 1'b1;
              short_frame <= short_next;
              crc_ok      <= ok_next;
              crc_err     <= !ok_next;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_irda_mir_rx_crc_check.sv
// Randomised self-checking bench for irda_mir_rx_crc_check against a frame-level CRC model.
module tb_irda_mir_rx_crc_check;

  localparam int MIN_DATA_BITS = 8;
  localparam int CNT_W         = 16;

  logic             clk = 1'b0;
  logic             wb_rst_i = 1'b1;
  logic             rx_start = 1'b0;
  logic             mir_rxbit_enable = 1'b0;
  logic             rxdin = 1'b0;
  logic             rx_end = 1'b0;
  logic             rxdout;
  logic             rxdout_valid;
  logic             crc_done;
  logic             crc_ok;
  logic             crc_err;
  logic             short_frame;
  logic [CNT_W-1:0] bit_count;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int both_high = 0;

  bit          frame_q[$];
  bit          out_q[$];
  bit          res_ok_q[$];
  bit          res_err_q[$];
  bit          res_short_q[$];
  logic [15:0] res_cnt_q[$];

  irda_mir_rx_crc_check #(
    .MIN_DATA_BITS (MIN_DATA_BITS),
    .CNT_W         (CNT_W)
  ) dut (
    .clk              (clk),
    .wb_rst_i         (wb_rst_i),
    .rx_start         (rx_start),
    .mir_rxbit_enable (mir_rxbit_enable),
    .rxdin            (rxdin),
    .rx_end           (rx_end),
    .rxdout           (rxdout),
    .rxdout_valid     (rxdout_valid),
    .crc_done         (crc_done),
    .crc_ok           (crc_ok),
    .crc_err          (crc_err),
    .short_frame      (short_frame),
    .bit_count        (bit_count)
  );

  always #5 clk = ~clk;

  // Observe outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rxdout_valid) out_q.push_back(rxdout);
    if (crc_done) begin
      res_ok_q.push_back(crc_ok);
      res_err_q.push_back(crc_err);
      res_short_q.push_back(short_frame);
      res_cnt_q.push_back(bit_count);
    end
    if (crc_ok && crc_err) both_high++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    out_q.delete();
    res_ok_q.delete();
    res_err_q.delete();
    res_short_q.delete();
    res_cnt_q.delete();
  endtask

  // Textbook MSB-first CRC-CCITT16 long division over the first n frame bits.
  function automatic logic [15:0] model_crc(input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      if (c[15] ^ frame_q[i]) c = (c << 1) ^ 16'h1021;
      else                    c = c << 1;
    end
    return c;
  endfunction

  task automatic load_good(input logic [15:0] fcs);
    string s;
    byte   c;
    s = "123456789";
    frame_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      for (int b = 7; b >= 0; b--) frame_q.push_back(c[b]);
    end
    for (int b = 15; b >= 0; b--) frame_q.push_back(fcs[b]);
  endtask

  task automatic load_random(input int n, input bit make_good);
    logic [15:0] fcs;
    frame_q.delete();
    if (make_good && n >= 16) begin
      for (int i = 0; i < n - 16; i++) frame_q.push_back(1'($urandom_range(0, 1)));
      fcs = ~model_crc(n - 16);
      for (int b = 15; b >= 0; b--) frame_q.push_back(fcs[b]);
    end else begin
      for (int i = 0; i < n; i++) frame_q.push_back(1'($urandom_range(0, 1)));
    end
  endtask

  task automatic send_frame(input bit coincide_end, input bit use_gaps, input bit do_clear);
    if (do_clear) clear_obs();
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
    for (int i = 0; i < frame_q.size(); i++) begin
      if (use_gaps) repeat ($urandom_range(0, 2)) tick();
      mir_rxbit_enable = 1'b1;
      rxdin = frame_q[i];
      if (coincide_end && i == frame_q.size() - 1) rx_end = 1'b1;
      tick();
      mir_rxbit_enable = 1'b0;
      rx_end = 1'b0;
    end
    if (!(coincide_end && frame_q.size() > 0)) begin
      rx_end = 1'b1;
      tick();
      rx_end = 1'b0;
    end
  endtask

  task automatic check_frame(input string name);
    int          n;
    int          waited;
    int          exp_strb;
    int          bad;
    bit          exp_short;
    bit          exp_ok;
    logic [15:0] fcs;
    waited = 0;
    while (res_ok_q.size() == 0 && waited < 30) begin
      tick();
      waited++;
    end
    repeat (3) tick();
    n         = frame_q.size();
    exp_short = (n < 16 + MIN_DATA_BITS);
    fcs       = 16'h0000;
    if (n >= 16) for (int i = n - 16; i < n; i++) fcs = {fcs[14:0], frame_q[i]};
    exp_ok    = !exp_short && (fcs == ~model_crc(n - 16));
    exp_strb  = (n > 16) ? n - 16 : 0;

    total_cnt++;
    if (res_ok_q.size() !== 1)
      $display("[TB] FAIL %s done_count: got %0d expected 1", name, res_ok_q.size());
    else pass_cnt++;
    if (res_ok_q.size() > 0) begin
      total_cnt++;
      if (res_ok_q[0] !== exp_ok)
        $display("[TB] FAIL %s crc_ok: got %0b expected %0b", name, res_ok_q[0], exp_ok);
      else pass_cnt++;
      total_cnt++;
      if (res_err_q[0] !== !exp_ok)
        $display("[TB] FAIL %s crc_err: got %0b expected %0b", name, res_err_q[0], !exp_ok);
      else pass_cnt++;
      total_cnt++;
      if (res_short_q[0] !== exp_short)
        $display("[TB] FAIL %s short_frame: got %0b expected %0b", name, res_short_q[0], exp_short);
      else pass_cnt++;
      total_cnt++;
      if (res_cnt_q[0] !== 16'(n))
        $display("[TB] FAIL %s bit_count: got %0d expected %0d", name, res_cnt_q[0], n);
      else pass_cnt++;
    end
    total_cnt++;
    if (out_q.size() !== exp_strb)
      $display("[TB] FAIL %s strobes: got %0d expected %0d", name, out_q.size(), exp_strb);
    else pass_cnt++;
    bad = 0;
    for (int i = 0; i < out_q.size() && i < exp_strb; i++)
      if (out_q[i] !== frame_q[i]) bad++;
    total_cnt++;
    if (bad !== 0)
      $display("[TB] FAIL %s payload_bits: got %0d wrong expected 0 wrong", name, bad);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({rxdout, rxdout_valid, crc_done, crc_ok, crc_err, short_frame} !== 6'b0)
      $display("[TB] FAIL reset_flags: got %06b expected 000000",
               {rxdout, rxdout_valid, crc_done, crc_ok, crc_err, short_frame});
    else pass_cnt++;
    total_cnt++;
    if (bit_count !== '0)
      $display("[TB] FAIL reset_bit_count: got %0d expected 0", bit_count);
    else pass_cnt++;
  endtask

  task automatic test_good_frame();
    load_good(16'hD64E);
    send_frame(1'b0, 1'b1, 1'b1);
    check_frame("good_frame");
  endtask

  task automatic test_bad_crc();
    load_good(16'hD64F);
    send_frame(1'b0, 1'b0, 1'b1);
    check_frame("bad_crc");
  endtask

  task automatic test_short();
    load_random(20, 1'b0);
    send_frame(1'b0, 1'b1, 1'b1);
    check_frame("short_20");
    load_random(10, 1'b0);
    send_frame(1'b0, 1'b0, 1'b1);
    check_frame("short_10");
  endtask

  task automatic test_abort();
    clear_obs();
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      mir_rxbit_enable = 1'b1;
      rxdin = 1'($urandom_range(0, 1));
      tick();
    end
    mir_rxbit_enable = 1'b0;
    tick();
    load_good(16'hD64E);
    send_frame(1'b0, 1'b0, 1'b1);
    check_frame("abort_restart");
  endtask

  task automatic test_simultaneous();
    load_good(16'hD64E);
    send_frame(1'b1, 1'b0, 1'b1);
    check_frame("end_with_last_bit");
    clear_obs();
    rx_start = 1'b1;
    mir_rxbit_enable = 1'b1;
    rxdin = 1'b1;
    tick();
    rx_start = 1'b0;
    mir_rxbit_enable = 1'b0;
    total_cnt++;
    if (bit_count !== 16'd1)
      $display("[TB] FAIL start_with_bit count: got %0d expected 1", bit_count);
    else pass_cnt++;
    frame_q.delete();
    frame_q.push_back(1'b1);
    rx_end = 1'b1;
    tick();
    rx_end = 1'b0;
    check_frame("start_with_bit");
  endtask

  task automatic test_back_to_back();
    load_good(16'hD64E);
    send_frame(1'b0, 1'b0, 1'b1);
    send_frame(1'b1, 1'b1, 1'b0);
    repeat (5) tick();
    total_cnt++;
    if (res_ok_q.size() !== 2)
      $display("[TB] FAIL back_to_back done_count: got %0d expected 2", res_ok_q.size());
    else pass_cnt++;
    if (res_ok_q.size() == 2) begin
      total_cnt++;
      if ({res_ok_q[0], res_ok_q[1]} !== 2'b11)
        $display("[TB] FAIL back_to_back crc_ok: got %02b expected 11", {res_ok_q[0], res_ok_q[1]});
      else pass_cnt++;
    end
    total_cnt++;
    if (out_q.size() !== 144)
      $display("[TB] FAIL back_to_back strobes: got %0d expected 144", out_q.size());
    else pass_cnt++;
  endtask

  task automatic test_random();
    int n;
    bit co;
    for (int k = 0; k < 10; k++) begin
      n = $urandom_range(0, 70);
      load_random(n, 1'($urandom_range(0, 1)));
      co = (n > 0) && ($urandom_range(0, 1) == 1);
      send_frame(co, 1'($urandom_range(0, 1)), 1'b1);
      check_frame($sformatf("random_%0d", k));
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_obs();
    rx_start = 1'b1;
    tick();
    rx_start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      mir_rxbit_enable = 1'b1;
      rxdin = 1'($urandom_range(0, 1));
      tick();
    end
    mir_rxbit_enable = 1'b0;
    wb_rst_i = 1'b1;
    #1;
    total_cnt++;
    if ({rxdout_valid, crc_done, crc_ok, crc_err, short_frame} !== 5'b0 || bit_count !== '0)
      $display("[TB] FAIL reset_mid_frame outputs: got flags %05b count %0d expected 00000 count 0",
               {rxdout_valid, crc_done, crc_ok, crc_err, short_frame}, bit_count);
    else pass_cnt++;
    tick();
    wb_rst_i = 1'b0;
    tick();
    clear_obs();
    for (int i = 0; i < 3; i++) begin
      mir_rxbit_enable = 1'b1;
      rx_end = 1'b1;
      tick();
      mir_rxbit_enable = 1'b0;
      rx_end = 1'b0;
      tick();
    end
    repeat (3) tick();
    total_cnt++;
    if (res_ok_q.size() !== 0 || out_q.size() !== 0)
      $display("[TB] FAIL ignored_after_reset: got %0d dones %0d strobes expected 0 0",
               res_ok_q.size(), out_q.size());
    else pass_cnt++;
    total_cnt++;
    if (bit_count !== '0)
      $display("[TB] FAIL idle_bit_count: got %0d expected 0", bit_count);
    else pass_cnt++;
  endtask

  initial begin
    repeat (3) tick();
    test_reset();
    wb_rst_i = 1'b0;
    tick();
    test_good_frame();
    test_bad_crc();
    test_short();
    test_abort();
    test_simultaneous();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    total_cnt++;
    if (both_high !== 0)
      $display("[TB] FAIL ok_err_exclusive: got %0d overlapping cycles expected 0", both_high);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/irda_mir_rx_crc_check.md
Name: irda_mir_rx_crc_check

Overview:
Receive-side companion of the MIR serial CRC-CCITT16 generator (x16+x12+x5+1, preset 16'hFFFF, FCS sent inverted, MSB first). It checks the serial MIR bit stream after unstuffing and flag removal. It forwards payload bits with the trailing 16-bit FCS stripped, and reports CRC pass/fail and short-frame errors at end of frame. It sits between the MIR bit de-stuffer and the RX byte assembler / RX FIFO.

Parameters:
MIN_DATA_BITS, 8, minimum payload bits (excluding FCS) for a frame to be valid.
CNT_W, 16, width of the received-bit counter; the counter saturates at all-ones.

Ports:
clk  input  1  system clock
wb_rst_i  input  1  asynchronous active-high reset
rx_start  input  1  one-cycle pulse at opening flag; restarts the checker
mir_rxbit_enable  input  1  qualifies rxdin; one bit consumed per asserted cycle
rxdin  input  1  serial received bit (data then FCS, MSB first)
rx_end  input  1  one-cycle pulse at closing flag, after the last FCS bit
rxdout  output  1  delayed payload bit (FCS never appears here)
rxdout_valid  output  1  one-cycle strobe qualifying rxdout
crc_done  output  1  one-cycle pulse: frame result valid
crc_ok  output  1  level, valid with crc_done, held until next rx_start
crc_err  output  1  level, valid with crc_done, held until next rx_start
short_frame  output  1  level, valid with crc_done, held until next rx_start
bit_count  output  CNT_W  total bits received in current frame, data plus FCS

Behaviour:
- Reset is asynchronous on wb_rst_i, active-high; clock is clk. On reset: state IDLE, crc register 16'hFFFF, delay line 0, bit_count 0, all outputs 0.
- CRC update on each accepted bit: s = crc[15]^rxdin; crc = {crc[14:12], crc[11]^s, crc[10:5], crc[4]^s, crc[3:0], s}.
- Accepted bits run through the CRC, including the FCS bits. For a good frame the residue is 16'h1D0F.
- Delay line: 16-bit shift register. Each accepted bit enters at bit 0 and the oldest bit leaves from bit 15.
- States: IDLE, FILL, RUN, DONE.
- IDLE: enables and rx_end are ignored. rx_start goes to FILL.
- FILL and RUN accept bits. On entry (via rx_start) crc=FFFF, bit_count=0, delay line=0, and crc_ok/crc_err/short_frame are cleared.
- FILL: each accepted bit increments bit_count. No rxdout_valid is produced. When the 16th bit is accepted, go to RUN.
- RUN: each accepted bit asserts rxdout_valid the next cycle, with rxdout equal to the bit shifted out of position 15. Latency is therefore 16 accepted bits plus 1 clk.
- rx_end in FILL or RUN goes to DONE. If an enable coincides with rx_end, that bit is accepted first.
- DONE lasts one cycle, then returns to IDLE. During DONE:
  - crc_done=1.
  - short_frame = (bit_count < 16+MIN_DATA_BITS).
  - crc_ok = !short_frame && crc==16'h1D0F.
  - crc_err = !crc_ok.
- rx_start has priority in every state, including DONE and mid-frame. It restarts at FILL and discards the old frame with no crc_done. An enable in the same cycle as rx_start is the first bit of the new frame.
- bit_count saturates at 2^CNT_W-1 and does not wrap. Once saturated, short_frame is 0.
- crc_ok and crc_err are never both 1. Both are 0 outside a completed frame.

Decomposition:
- Shared package irda_pkg holds: CRC16_POLY=16'h1021, CRC16_PRESET=16'hFFFF, CRC16_RESIDUE=16'h1D0F, and the state enum typedef rx_crc_state_t.
- One natural sub-module, irda_crc16_step: a combinational one-bit CRC update that the TX generator can also reuse.

Test Plan:
- Good frame: ASCII "123456789" (72 bits, MSB first per byte) then FCS 16'hD64E MSB first, then rx_end. Required: crc_ok=1, crc_err=0, bit_count=88, exactly 72 rxdout_valid strobes reproducing the payload, no FCS bits forwarded.
- Bad CRC: same frame with FCS 16'hD64F. Required: crc_err=1, crc_ok=0, short_frame=0, 72 payload strobes.
- Short frame: 20 bits then rx_end. Required: short_frame=1, crc_err=1, 4 rxdout_valid strobes. Then 10 bits then rx_end, required: 0 strobes, short_frame=1.
- Abort and restart: rx_start after 40 bits of frame A, then the good frame of scenario 1. Required: no crc_done for A, single crc_done with crc_ok=1 for B.
- Simultaneous events: last FCS bit with rx_end in the same cycle gives crc_ok=1. rx_start with enable in the same cycle counts that bit as bit 1 (bit_count=1).
- Reset mid-frame: assert wb_rst_i after 50 bits. Required: all outputs 0 immediately; later rx_end pulses are ignored until rx_start.
